// File: rtl/load_store_unit_pkg.sv
// Shared control-signal types for the core's memory path.
// memSize_t encodes access size as log2 of the byte count, matching funct3[1:0].
package ControlSignals;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } memSize_t;

  function automatic int size_bytes(memSize_t size);
    return 1 << int'(size);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering for the load/store unit: store shift and byte
// enables plus error detection on the incoming request, load extract/extend on the latched one.
module lsu_align
  import ControlSignals::*;
#(
  parameter  int DATA_WIDTH_POW = 6,
  localparam int DW             = 1 << DATA_WIDTH_POW,
  localparam int NB             = DW / 8,
  localparam int OFF_W          = DATA_WIDTH_POW - 3
) (
  input  logic [2:0]       st_funct3,
  input  logic             st_write,
  input  logic [OFF_W-1:0] st_off,
  input  logic [DW-1:0]    st_data,
  input  logic [2:0]       ld_funct3,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [DW-1:0]    rdata,
  output logic [DW-1:0]    wdata,
  output logic [NB-1:0]    byte_en,
  output logic             err,
  output logic [DW-1:0]    load_data
);

  memSize_t      st_size;
  memSize_t      ld_size;
  int            st_bytes;
  int            ld_bits;
  logic [15:0]   lane_mask;
  logic [DW-1:0] st_shifted;
  logic [DW-1:0] rd_shifted;
  logic          sign;

  assign st_size = memSize_t'(st_funct3[1:0]);
  assign ld_size = memSize_t'(ld_funct3[1:0]);

  // Oversized accesses may overflow the mask; they are flagged as errors and never reach memory.
  always_comb begin
    st_bytes   = size_bytes(st_size);
    lane_mask  = ((16'd1 << st_bytes) - 16'd1) << st_off;
    byte_en    = lane_mask[NB-1:0];
    st_shifted = st_data << (8 * int'(st_off));
    wdata      = '0;
    for (int b = 0; b < NB; b++) begin
      wdata[8*b +: 8] = byte_en[b] ? st_shifted[8*b +: 8] : 8'h00;
    end
    err = ((int'(st_off) & (st_bytes - 1)) != 0)
       || (int'(st_size) > OFF_W)
       || (st_funct3[2] && (st_write || int'(st_size) == OFF_W));
  end

  always_comb begin
    ld_bits    = 8 << int'(ld_size);
    rd_shifted = rdata >> (8 * int'(ld_off));
    sign       = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i == ld_bits - 1) sign = rd_shifted[i];
    end
    if (ld_funct3[2]) sign = 1'b0;
    load_data = '0;
    for (int i = 0; i < DW; i++) begin
      load_data[i] = (i < ld_bits) ? rd_shifted[i] : sign;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory: ready/valid request, variable-latency
// memory handshake, one-cycle registered response pulse.
module load_store_unit
  import ControlSignals::*;
#(
  parameter  int DATA_WIDTH_POW = 6,
  parameter  int ADDR_WIDTH_POW = 6,
  localparam int DW             = 1 << DATA_WIDTH_POW,
  localparam int AW             = 1 << ADDR_WIDTH_POW,
  localparam int NB             = DW / 8,
  localparam int OFF_W          = DATA_WIDTH_POW - 3
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          req_valid_in,
  output logic          req_ready_out,
  input  logic          req_write_in,
  input  logic [2:0]    req_funct3_in,
  input  logic [AW-1:0] req_addr_in,
  input  logic [DW-1:0] req_data_in,
  output logic          mem_req_valid_out,
  input  logic          mem_req_ready_in,
  output logic          mem_write_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  output logic [NB-1:0] mem_byteEn_out,
  input  logic          mem_rvalid_in,
  input  logic [DW-1:0] mem_rdata_in,
  output logic          resp_valid_out,
  output logic [DW-1:0] resp_data_out,
  output logic          resp_err_out,
  output logic          busy_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} lsuState_t;

  lsuState_t        state;
  lsuState_t        next_state;
  logic             accept;
  logic             enter_resp;
  logic             write_q;
  logic [2:0]       funct3_q;
  logic [OFF_W-1:0] off_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic [NB-1:0]    mem_byte_en_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [DW-1:0]    resp_data_q;
  logic [DW-1:0]    st_wdata;
  logic [NB-1:0]    st_byte_en;
  logic             st_err;
  logic [DW-1:0]    load_data;

  lsu_align #(.DATA_WIDTH_POW(DATA_WIDTH_POW)) u_align (
    .st_funct3 (req_funct3_in),
    .st_write  (req_write_in),
    .st_off    (req_addr_in[OFF_W-1:0]),
    .st_data   (req_data_in),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .rdata     (mem_rdata_in),
    .wdata     (st_wdata),
    .byte_en   (st_byte_en),
    .err       (st_err),
    .load_data (load_data)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_in) begin
          accept     = 1'b1;
          next_state = st_err ? RESP : REQ;
        end
      end
      REQ:    if (mem_req_ready_in) next_state = write_q ? RESP : WAIT_R;
      WAIT_R: if (mem_rvalid_in) next_state = RESP;
      RESP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    enter_resp = (next_state == RESP);
  end

  // Entering RESP straight from IDLE only happens for a rejected request, hence the error flag.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= IDLE;
      write_q       <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state        <= next_state;
      resp_valid_q <= enter_resp;
      resp_err_q   <= enter_resp && (state == IDLE);
      resp_data_q  <= (enter_resp && state == WAIT_R) ? load_data : '0;
      if (accept) begin
        write_q       <= req_write_in;
        funct3_q      <= req_funct3_in;
        off_q         <= req_addr_in[OFF_W-1:0];
        mem_addr_q    <= {req_addr_in[AW-1:OFF_W], {OFF_W{1'b0}}};
        mem_wdata_q   <= st_wdata;
        mem_byte_en_q <= st_byte_en;
      end
    end
  end

  assign req_ready_out     = (state == IDLE) && !reset;
  assign busy_out          = (state != IDLE);
  assign mem_req_valid_out = (state == REQ);
  assign mem_write_out     = write_q;
  assign mem_addr_out      = mem_addr_q;
  assign mem_wdata_out     = mem_wdata_q;
  assign mem_byteEn_out    = mem_byte_en_q;
  assign resp_valid_out    = resp_valid_q;
  assign resp_err_out      = resp_err_q;
  assign resp_data_out     = resp_data_q;

endmodule
